// File: rtl/z80fi_insn_capture_if.sv
// z80fi_insn_capture_if: core fetch/retire inputs and the z80fi record outputs
// of the instruction capture block, grouped into one bundle.
// master = core / stimulus side, slave = the capture block.
// Optional macro Z80FI_INSN_ORDER_EN adds the z80fi_order retirement number.
interface z80fi_insn_capture_if #(
    parameter int MAX_LEN = 4,
    parameter int REGS_W  = 80
);
    // core side
    logic                   fetch_valid;
    logic                   fetch_start;
    logic [7:0]             fetch_byte;
    logic                   insn_done;
    logic [REGS_W-1:0]      core_regs;

    // record side
    logic                   z80fi_valid;
    logic [8*MAX_LEN-1:0]   z80fi_insn;
    logic [2:0]             z80fi_insn_len;
    logic [REGS_W-1:0]      z80fi_regs_in;
    logic [REGS_W-1:0]      z80fi_regs_out;
    logic                   z80fi_err;
`ifdef Z80FI_INSN_ORDER_EN
    logic [63:0]            z80fi_order;
`endif

    modport master (
        output fetch_valid, fetch_start, fetch_byte, insn_done, core_regs,
`ifdef Z80FI_INSN_ORDER_EN
        input  z80fi_order,
`endif
        input  z80fi_valid, z80fi_insn, z80fi_insn_len,
               z80fi_regs_in, z80fi_regs_out, z80fi_err
    );

    modport slave (
        input  fetch_valid, fetch_start, fetch_byte, insn_done, core_regs,
`ifdef Z80FI_INSN_ORDER_EN
        output z80fi_order,
`endif
        output z80fi_valid, z80fi_insn, z80fi_insn_len,
               z80fi_regs_in, z80fi_regs_out, z80fi_err
    );
endinterface

// File: rtl/z80fi_insn_capture.sv
// z80fi_insn_capture: assembles the raw bytes of each instruction the core
// fetches, snapshots the register file at instruction start and retirement,
// and emits one single-cycle z80fi_valid record per retired instruction.
// Optional macro Z80FI_INSN_ORDER_EN adds a 64-bit retirement sequence number.
//
// Structure: a collecting shadow (bytes, length, start registers) fills while
// the instruction is in flight; on insn_done the shadow -- including a byte
// fetched in that same cycle -- is copied into separate output registers, so
// a new instruction may start in the retire cycle without disturbing the
// record being presented.
module z80fi_insn_capture #(
    parameter int MAX_LEN = 4,
    parameter int REGS_W  = 80
) (
    input  logic                 clk,
    input  logic                 reset,
    z80fi_insn_capture_if.slave  cap_if
);

    localparam int         INSN_W  = 8 * MAX_LEN;
    localparam logic [2:0] LEN_MAX = 3'(MAX_LEN);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    state_e                     state_q, state_d;

    // collecting shadow
    logic [MAX_LEN-1:0][7:0]    shadow_q, shadow_d;
    logic [2:0]                 len_q, len_d;
    logic [REGS_W-1:0]          rin_q, rin_d;

    // presented record
    logic                       valid_q, valid_d;
    logic [INSN_W-1:0]          insn_q, insn_d;
    logic [2:0]                 olen_q, olen_d;
    logic [REGS_W-1:0]          oregs_in_q, oregs_in_d;
    logic [REGS_W-1:0]          oregs_out_q, oregs_out_d;
    logic                       err_q, err_d;

`ifdef Z80FI_INSN_ORDER_EN
    logic [63:0]                seq_q, seq_d;      // number for the next retirement
    logic [63:0]                order_q, order_d;  // number of the presented record
`endif

    // ---------------------------------------------------------------
    // Event decode
    // ---------------------------------------------------------------
    logic                       start;    // first byte of a new instruction
    logic                       append;   // continuation byte while collecting
    logic                       ovf;      // continuation byte with shadow full
    logic                       retire;   // current instruction retires
    logic [MAX_LEN-1:0][7:0]    merged;   // shadow including this cycle's byte
    logic [2:0]                 merged_len;

    assign start  = cap_if.fetch_valid & cap_if.fetch_start;
    assign append = (state_q == COLLECT) & cap_if.fetch_valid & ~cap_if.fetch_start;
    assign ovf    = append & (len_q == LEN_MAX);
    assign retire = (state_q == COLLECT) & cap_if.insn_done;

    // Fold a same-cycle continuation byte into the shadow view so that both
    // the retiring record and the ongoing collection see it.
    always_comb begin
        merged     = shadow_q;
        merged_len = len_q;
        if (append && !ovf) begin
            for (int k = 0; k < MAX_LEN; k++) begin
                if (len_q == 3'(k)) begin
                    merged[k] = cap_if.fetch_byte;
                end
            end
            merged_len = len_q + 3'd1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, shadow update, record capture and error detection.
    always_comb begin
        state_d     = state_q;
        shadow_d    = merged;
        len_d       = merged_len;
        rin_d       = rin_q;
        valid_d     = 1'b0;
        insn_d      = insn_q;
        olen_d      = olen_q;
        oregs_in_d  = oregs_in_q;
        oregs_out_d = oregs_out_q;
        err_d       = err_q;
`ifdef Z80FI_INSN_ORDER_EN
        seq_d       = seq_q;
        order_d     = order_q;
`endif

        // Protocol errors are sticky until reset.
        if (state_q == IDLE) begin
            // orphan continuation byte, or a retire with nothing in flight
            if ((cap_if.fetch_valid && !cap_if.fetch_start) || cap_if.insn_done) begin
                err_d = 1'b1;
            end
        end else begin
            // overflow, or a new start while the previous one never retired
            if (ovf || (start && !cap_if.insn_done)) begin
                err_d = 1'b1;
            end
        end

        // Retirement: present the shadow next cycle, registers sampled now.
        if (retire) begin
            valid_d     = 1'b1;
            insn_d      = merged;
            olen_d      = merged_len;
            oregs_in_d  = rin_q;
            oregs_out_d = cap_if.core_regs;
            state_d     = IDLE;
`ifdef Z80FI_INSN_ORDER_EN
            order_d     = seq_q;
            seq_d       = seq_q + 64'd1;
`endif
        end

        // A start byte always begins a fresh capture. In COLLECT without a
        // retire this silently discards the unretired instruction.
        if (start) begin
            shadow_d    = '0;
            shadow_d[0] = cap_if.fetch_byte;
            len_d       = 3'd1;
            rin_d       = cap_if.core_regs;
            state_d     = COLLECT;
        end
    end

    // Shadow and output record registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q    <= '0;
            len_q       <= '0;
            rin_q       <= '0;
            valid_q     <= 1'b0;
            insn_q      <= '0;
            olen_q      <= '0;
            oregs_in_q  <= '0;
            oregs_out_q <= '0;
            err_q       <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            len_q       <= len_d;
            rin_q       <= rin_d;
            valid_q     <= valid_d;
            insn_q      <= insn_d;
            olen_q      <= olen_d;
            oregs_in_q  <= oregs_in_d;
            oregs_out_q <= oregs_out_d;
            err_q       <= err_d;
        end
    end

`ifdef Z80FI_INSN_ORDER_EN
    // Retirement sequence counter; discarded instructions never advance it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_q   <= '0;
            order_q <= '0;
        end else begin
            seq_q   <= seq_d;
            order_q <= order_d;
        end
    end

    assign cap_if.z80fi_order = order_q;
`endif

    assign cap_if.z80fi_valid    = valid_q;
    assign cap_if.z80fi_insn     = insn_q;
    assign cap_if.z80fi_insn_len = olen_q;
    assign cap_if.z80fi_regs_in  = oregs_in_q;
    assign cap_if.z80fi_regs_out = oregs_out_q;
    assign cap_if.z80fi_err      = err_q;

endmodule

// File: tb/tb_z80fi_insn_capture.sv
// Bench for z80fi_insn_capture: directed test-plan scenarios followed by
// random fetch/retire traffic. A byte-queue model predicts each record into
// a scoreboard; a negedge monitor pops and compares on every z80fi_valid.
module tb_z80fi_insn_capture;

    localparam int MAX_LEN = 4;
    localparam int REGS_W  = 80;
    localparam int INSN_W  = 8 * MAX_LEN;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    z80fi_insn_capture_if #(.MAX_LEN(MAX_LEN), .REGS_W(REGS_W)) bif ();

    z80fi_insn_capture #(.MAX_LEN(MAX_LEN), .REGS_W(REGS_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .cap_if (bif)
    );

    typedef struct {
        logic [INSN_W-1:0] insn;
        logic [2:0]        len;
        logic [REGS_W-1:0] rin;
        logic [REGS_W-1:0] rout;
        logic              err;
        logic [63:0]       order;
    } rec_t;

    rec_t exp_q[$];
    rec_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model: instruction in flight as a plain byte list
    logic [7:0]        m_bytes[$];
    bit                m_active;
    bit                m_err;
    logic [REGS_W-1:0] m_rin;
    logic [63:0]       m_order;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [INSN_W-1:0] pack_bytes();
        logic [INSN_W-1:0] r = '0;
        foreach (m_bytes[i]) r[8*i +: 8] = m_bytes[i];
        return r;
    endfunction

    function automatic logic [REGS_W-1:0] rnd_regs();
        logic [REGS_W-1:0] r;
        r = {16'($urandom()), $urandom(), $urandom()};
        return r;
    endfunction

    function automatic logic [REGS_W-1:0] regs_ip(input logic [15:0] ip);
        logic [REGS_W-1:0] r;
        r = rnd_regs();
        r[79:64] = ip;
        return r;
    endfunction

    // Drive one cycle of core activity, advance the model, wait past the edge.
    task automatic cyc(input bit fv, input bit fs, input logic [7:0] b,
                       input bit done, input logic [REGS_W-1:0] regs);
        rec_t r;
        bit   ret = 0;
        bif.fetch_valid = fv;
        bif.fetch_start = fs;
        bif.fetch_byte  = b;
        bif.insn_done   = done;
        bif.core_regs   = regs;
        if (!m_active) begin
            if (done || (fv && !fs)) m_err = 1;
            if (fv && fs) begin
                m_bytes  = {b};
                m_rin    = regs;
                m_active = 1;
            end
        end else begin
            if (fv && !fs) begin
                if (m_bytes.size() < MAX_LEN) m_bytes.push_back(b);
                else m_err = 1;
            end
            if (done) begin
                ret     = 1;
                r.insn  = pack_bytes();
                r.len   = 3'(m_bytes.size());
                r.rin   = m_rin;
                r.rout  = regs;
                r.order = m_order;
                m_order = m_order + 64'd1;
            end
            if (fv && fs) begin
                if (!done) m_err = 1;
                m_bytes = {b};
                m_rin   = regs;
            end else if (done) begin
                m_active = 0;
            end
        end
        if (ret) begin
            r.err = m_err;
            exp_q.push_back(r);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 8'h00, 0, rnd_regs());
    endtask

    // Two quiet cycles let any pending record drain, then reset mid-cycle
    // and check every output is zero while reset is held.
    task automatic do_reset();
        idle(2);
        reset = 1'b1;
        #2;
        chk("rst_valid",    bif.z80fi_valid,    '0);
        chk("rst_insn",     bif.z80fi_insn,     '0);
        chk("rst_len",      bif.z80fi_insn_len, '0);
        chk("rst_regs_in",  bif.z80fi_regs_in,  '0);
        chk("rst_regs_out", bif.z80fi_regs_out, '0);
        chk("rst_err",      bif.z80fi_err,      '0);
`ifdef Z80FI_INSN_ORDER_EN
        chk("rst_order",    bif.z80fi_order,    '0);
`endif
        @(posedge clk);
        #1;
        reset    = 1'b0;
        m_active = 0;
        m_err    = 0;
        m_order  = '0;
        m_bytes.delete();
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset && bif.z80fi_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got valid=1 with insn=%0h expected no record",
                         bif.z80fi_insn);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rec_insn",     bif.z80fi_insn,     mon_e.insn);
                chk("rec_len",      bif.z80fi_insn_len, mon_e.len);
                chk("rec_regs_in",  bif.z80fi_regs_in,  mon_e.rin);
                chk("rec_regs_out", bif.z80fi_regs_out, mon_e.rout);
                chk("rec_err",      bif.z80fi_err,      mon_e.err);
`ifdef Z80FI_INSN_ORDER_EN
                chk("rec_order",    bif.z80fi_order,    mon_e.order);
`endif
            end
        end
    end

    initial begin
        bit fv, fs, dn;
        bif.fetch_valid = 0;
        bif.fetch_start = 0;
        bif.fetch_byte  = '0;
        bif.insn_done   = 0;
        bif.core_regs   = '0;
        m_active = 0;
        m_err    = 0;
        m_order  = '0;
        #3;
        do_reset();

        // CB 07 rotate
        cyc(1, 1, 8'hCB, 0, regs_ip(16'h1000));
        cyc(1, 0, 8'h07, 0, regs_ip(16'h1001));
        cyc(0, 0, 8'h00, 1, regs_ip(16'h1002));
        chk("cb07_valid",   bif.z80fi_valid, 1'b1);
        chk("cb07_insn",    bif.z80fi_insn, 32'h0000_07CB);
        chk("cb07_len",     bif.z80fi_insn_len, 3'd2);
        chk("cb07_ip_in",   bif.z80fi_regs_in[79:64], 16'h1000);
        chk("cb07_ip_out",  bif.z80fi_regs_out[79:64], 16'h1002);
        chk("cb07_err",     bif.z80fi_err, 1'b0);
        idle(2);
        chk("hold_valid",   bif.z80fi_valid, 1'b0);
        chk("hold_insn",    bif.z80fi_insn, 32'h0000_07CB);

        // back-to-back retirements
        cyc(1, 1, 8'h00, 0, rnd_regs());
        cyc(1, 1, 8'h3E, 1, rnd_regs());
        chk("b2b_first",    bif.z80fi_insn, 32'h0000_0000);
        cyc(1, 0, 8'h42, 0, rnd_regs());
        cyc(0, 0, 8'h00, 1, rnd_regs());
        chk("b2b_second",   bif.z80fi_insn, 32'h0000_423E);
        chk("b2b_len",      bif.z80fi_insn_len, 3'd2);

        // reset mid-COLLECT, then a clean single-byte instruction
        cyc(1, 1, 8'h11, 0, rnd_regs());
        cyc(1, 0, 8'h22, 0, rnd_regs());
        do_reset();
        cyc(1, 1, 8'h5A, 0, rnd_regs());
        cyc(0, 0, 8'h00, 1, rnd_regs());
        chk("post_rst_len", bif.z80fi_insn_len, 3'd1);
        chk("post_rst_err", bif.z80fi_err, 1'b0);

        // overflow
        cyc(1, 1, 8'hDD, 0, rnd_regs());
        cyc(1, 0, 8'hCB, 0, rnd_regs());
        cyc(1, 0, 8'h05, 0, rnd_regs());
        cyc(1, 0, 8'h06, 0, rnd_regs());
        cyc(1, 0, 8'h07, 0, rnd_regs());
        cyc(0, 0, 8'h00, 1, rnd_regs());
        chk("ovf_insn",     bif.z80fi_insn, 32'h0605_CBDD);
        chk("ovf_len",      bif.z80fi_insn_len, 3'd4);
        chk("ovf_err",      bif.z80fi_err, 1'b1);

        // missing retire (discarded instruction consumes no order number)
        do_reset();
        cyc(1, 1, 8'h01, 1, rnd_regs());  // done in IDLE: ignored, err
        cyc(1, 1, 8'h02, 0, rnd_regs());  // discards 0x01
        cyc(0, 0, 8'h00, 1, rnd_regs());
        chk("miss_insn",    bif.z80fi_insn, 32'h0000_0002);
        chk("miss_err",     bif.z80fi_err, 1'b1);
        cyc(1, 1, 8'h76, 0, rnd_regs());
        cyc(1, 1, 8'h77, 1, rnd_regs());
        cyc(0, 0, 8'h00, 1, rnd_regs());

        // random traffic
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            fv = ($urandom_range(0, 99) < 70);
            fs = fv && ($urandom_range(0, 2) == 0);
            dn = ($urandom_range(0, 3) == 0);
            cyc(fv, fs, 8'($urandom()), dn, rnd_regs());
        end
        idle(3);
        chk("queue_drained", 80'(exp_q.size()), 80'd0);
        chk("final_err",     bif.z80fi_err, m_err);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
